replay_buffer: RTL and testbench

- Transmit-side retry buffer directly downstream of the LCRC generator (lcrc_32).
- Accepts LCRC-appended packets and assigns each a 12-bit sequence number.
- Forwards packets to the link and keeps every sent packet until it is acknowledged.
- On NAK, purges the acknowledged entries and replays all remaining unacknowledged packets in order, with their original sequence numbers.

---
 rtl/replay_buffer.sv | 91 +++++++++
 tb/tb_replay_buffer.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/replay_buffer.sv
// replay_buffer: transmit retry buffer holding sent packets until ACK, replaying them on NAK
module replay_buffer #(
  parameter int PACKET_SIZE = 128,
  parameter int DEPTH = 8,
  parameter int SEQ_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PACKET_SIZE+31:0]   in_pkt,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PACKET_SIZE+31:0]   out_pkt,
  output logic [SEQ_WIDTH-1:0]      out_seq,
  input  logic                      ack_valid,
  input  logic                      nak_valid,
  input  logic [SEQ_WIDTH-1:0]      ackd_seq,
  output logic                      full,
  output logic                      empty,
  output logic [1:0]                replay_num,
  output logic                      num_rollover
);
  localparam int W = PACKET_SIZE + 32;
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {NORMAL, REPLAY} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] head_q, head_d, tail, send_ptr;
  logic [AW:0] count_q, count_d, sent_q, sent_d, sent_eff, purge;
  logic [SEQ_WIDTH-1:0] next_seq_q, next_seq_d, head_seq, n;
  logic [1:0] replay_q, replay_d, replay_base;
  logic roll_q, roll_d, accept, fire, legal, restart;
  logic [W-1:0] mem [DEPTH];
  // The send pointer is kept as a sent-count so that full-and-all-sent is unambiguous
  assign tail = head_q + count_q[AW-1:0];
  assign send_ptr = head_q + sent_q[AW-1:0];
  assign head_seq = next_seq_q - SEQ_WIDTH'(count_q);
  assign out_seq = head_seq + SEQ_WIDTH'(sent_q);
  assign out_pkt = mem[send_ptr];
  assign full = count_q == (AW+1)'(DEPTH);
  assign empty = count_q == '0;
  assign replay_num = replay_q;
  assign num_rollover = roll_q;
  // Output decode: handshake availability depends only on registered state
  always_comb begin
    in_ready = !full && state_q == NORMAL;
    out_valid = sent_q < count_q;
  end
  // Next-state: purge on legal ACK/NAK, accept, send, and replay restart/completion
  always_comb begin
    accept = in_valid && in_ready;
    fire = out_valid && out_ready;
    sent_eff = sent_q + (AW+1)'(fire);
    n = ackd_seq - head_seq + SEQ_WIDTH'(1);
    legal = (ack_valid || nak_valid) && n <= SEQ_WIDTH'(sent_eff);
    purge = legal ? (AW+1)'(n) : '0;
    count_d = count_q + (AW+1)'(accept) - purge;
    restart = legal && nak_valid && count_d != '0;
    replay_base = (legal && n != '0) ? 2'd0 : replay_q;
    replay_d = restart ? replay_base + 2'd1 : replay_base;
    roll_d = restart && replay_base == 2'd3;
    sent_d = restart ? '0 : sent_eff - purge;
    head_d = head_q + AW'(purge);
    next_seq_d = next_seq_q + SEQ_WIDTH'(accept);
    state_d = restart ? REPLAY : (state_q == REPLAY && sent_d == count_d) ? NORMAL : state_q;
  end
  // State register with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= NORMAL;
      head_q <= '0;
      count_q <= '0;
      sent_q <= '0;
      next_seq_q <= '0;
      replay_q <= '0;
      roll_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q <= head_d;
      count_q <= count_d;
      sent_q <= sent_d;
      next_seq_q <= next_seq_d;
      replay_q <= replay_d;
      roll_q <= roll_d;
    end
  end
  // Packet storage, written at tail on accept and never cleared
  always_ff @(posedge clk) begin
    if (accept) mem[tail] <= in_pkt;
  end
endmodule

// File: tb/tb_replay_buffer.sv
// tb_replay_buffer: vector table, directed corner sequences and random traffic against a queue model
module tb_replay_buffer;
  localparam int PS = 32;
  localparam int W = PS + 32;
  localparam int D = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [W-1:0] in_pkt = '0, out_pkt;
  logic [11:0] out_seq, ackd_seq = '0;
  logic ack_valid = 1'b0, nak_valid = 1'b0, full, empty, num_rollover;
  logic [1:0] replay_num;
  int tests = 0, fails = 0;
  logic [W-1:0] mq[$];
  int msent, mnext, mrn;
  bit mrep, mroll;

  always #5 clk = ~clk;

  replay_buffer #(.PACKET_SIZE(PS), .DEPTH(D), .SEQ_WIDTH(12)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_pkt(in_pkt),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt), .out_seq(out_seq),
    .ack_valid(ack_valid), .nak_valid(nak_valid), .ackd_seq(ackd_seq), .full(full),
    .empty(empty), .replay_num(replay_num), .num_rollover(num_rollover)
  );

  typedef struct {
    bit iv, ordy, ack, nak;
    int seq;
    bit ov;
    int oseq;
    bit ir, fl, em;
    int rn;
    bit roll;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit iv, bit ordy, bit ack, bit nak, int seq, bit ov, int oseq,
                              bit ir, bit fl, bit em, int rn, bit roll);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.ack = ack; v.nak = nak; v.seq = seq; v.ov = ov; v.oseq = oseq;
    v.ir = ir; v.fl = fl; v.em = em; v.rn = rn; v.roll = roll;
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int sz;
    bit ov;
    sz = mq.size();
    ov = msent < sz;
    chk("out_valid", out_valid, ov);
    chk("in_ready", in_ready, sz < D && !mrep);
    chk("full", full, sz == D);
    chk("empty", empty, sz == 0);
    chk("replay_num", replay_num, mrn);
    chk("num_rollover", num_rollover, mroll);
    if (ov) begin
      chk("out_seq", out_seq, (mnext - sz + msent) & 'hFFF);
      chk("out_pkt", out_pkt, mq[msent]);
    end
  endtask

  task automatic cycle(bit iv, bit ordy, bit ack, bit nak, int seq);
    logic [W-1:0] pkt;
    int sz, s, hs, n;
    bit ov, ir, fire, acc, rs;
    pkt = {$urandom, $urandom};
    in_valid = iv; in_pkt = pkt; out_ready = ordy; ack_valid = ack; nak_valid = nak;
    ackd_seq = seq[11:0];
    sz = mq.size();
    ov = msent < sz;
    ir = sz < D && !mrep;
    fire = ov && ordy;
    acc = iv && ir;
    rs = 0;
    s = msent + int'(fire);
    mroll = 0;
    if (ack || nak) begin
      hs = (mnext - sz) & 'hFFF;
      n = (seq - hs + 1) & 'hFFF;
      if (n <= s) begin
        for (int k = 0; k < n; k++) void'(mq.pop_front());
        s -= n;
        if (n > 0) mrn = 0;
        if (nak && mq.size() + int'(acc) > 0) begin
          s = 0; rs = 1; mrep = 1;
          mroll = (mrn == 3);
          mrn = (mrn + 1) % 4;
        end
      end
    end
    if (acc) begin
      mq.push_back(pkt);
      mnext = (mnext + 1) % 4096;
    end
    if (!rs && mrep && s == mq.size()) mrep = 0;
    msent = s;
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 0; out_ready = 0; ack_valid = 0; nak_valid = 0;
    mq.delete();
    msent = 0; mnext = 0; mrn = 0; mrep = 0; mroll = 0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check_model();
  endtask

  initial begin
    do_reset();
    tbl.push_back(mk(1,0,0,0,0, 1,0,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1,1,1,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0, 1,2,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,1, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,5, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,1, 1,2,0,0,0,1,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,1,0,0,1,0));
    tbl.push_back(mk(0,0,1,0,2, 0,0,1,0,1,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,3,1,0,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,1,2, 1,3,0,0,0,1,0));
    tbl.push_back(mk(0,0,0,1,2, 1,3,0,0,0,2,0));
    tbl.push_back(mk(0,0,0,1,2, 1,3,0,0,0,3,0));
    tbl.push_back(mk(0,0,0,1,2, 1,3,0,0,0,0,1));
    tbl.push_back(mk(0,1,0,0,0, 0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,1,0,3, 0,0,1,0,1,0,0));
    for (int i = 0; i < 7; i++) tbl.push_back(mk(1,0,0,0,0, 1,4,1,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,4,0,1,0,0,0));
    tbl.push_back(mk(1,0,0,0,0, 1,4,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,5,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,6,0,1,0,0,0));
    tbl.push_back(mk(0,1,0,0,0, 1,7,0,1,0,0,0));
    tbl.push_back(mk(0,0,1,0,6, 1,7,1,0,0,0,0));
    foreach (tbl[i]) begin
      cycle(tbl[i].iv, tbl[i].ordy, tbl[i].ack, tbl[i].nak, tbl[i].seq);
      chk($sformatf("vec%0d_ov", i), out_valid, tbl[i].ov);
      if (tbl[i].ov) chk($sformatf("vec%0d_seq", i), out_seq, tbl[i].oseq);
      chk($sformatf("vec%0d_ir", i), in_ready, tbl[i].ir);
      chk($sformatf("vec%0d_full", i), full, tbl[i].fl);
      chk($sformatf("vec%0d_empty", i), empty, tbl[i].em);
      chk($sformatf("vec%0d_rn", i), replay_num, tbl[i].rn);
      chk($sformatf("vec%0d_roll", i), num_rollover, tbl[i].roll);
    end

    do_reset();
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("nak_send_seq", out_seq, i);
      cycle(0, 1, 0, 0, 0);
    end
    cycle(0, 0, 0, 1, 0);
    chk("nak_in_ready", in_ready, 0);
    for (int i = 1; i < 4; i++) begin
      chk("nak_replay_seq", out_seq, i);
      cycle(0, 1, 0, 0, 0);
    end
    chk("nak_done_ready", in_ready, 1);
    chk("nak_done_valid", out_valid, 0);
    chk("nak_replay_num", replay_num, 1);

    do_reset();
    for (int i = 0; i < 4094; i++) begin
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 1, 0, i);
    end
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("wrap_seq", out_seq, (4094 + i) % 4096);
      cycle(0, 1, 0, 0, 0);
    end
    cycle(0, 0, 1, 0, 0);
    chk("wrap_empty", empty, 1);

    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int hs, seq;
      if (i == 2000) do_reset();
      hs = (mnext - mq.size()) & 'hFFF;
      seq = ($urandom % 4 == 0) ? int'($urandom % 4096) : ((hs - 1 + int'($urandom_range(0, msent + 1))) & 'hFFF);
      cycle($urandom % 2 == 0, $urandom % 10 < 7, $urandom % 8 == 0, $urandom % 16 == 0, seq);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
